// File: rtl/mem_resp_if.sv
// Bus between the CPU sequencer and the memory responder.
//   rd, wr      : level-held read/write requests (CPU -> memory)
//   addr, wdata : word address and write data, sampled at request acceptance
//   rdata       : registered read data (memory -> CPU)
//   kp          : keep/wait, 1 while an access is in progress (memory -> CPU)
//   busy        : registered, 1 while the responder is in its BUSY state
interface mem_resp_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          kp;
  logic          busy;

  modport master (output rd, wr, addr, wdata, input rdata, kp, busy);
  modport slave  (input rd, wr, addr, wdata, output rdata, kp, busy);
endinterface

// File: rtl/mem_resp.sv
// Memory-side responder: single-port DW x 2^AW array with a fixed number of
// wait states per access. kp stays high while an access is in progress and
// drops in the completion (DONE) cycle, when rdata is already valid.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_resp_if slave modport (rd, wr, addr, wdata in; rdata, kp, busy out)
module mem_resp #(
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);

  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          op_wr_q;
  logic [DW-1:0] mem [DEPTH];

  logic req;
  logic last;
  logic mem_we;

  assign req  = bus.rd | bus.wr;
  assign last = (cnt == CW'(WAIT - 1));

  // Array write happens on the BUSY->DONE edge of a write that was not aborted.
  assign mem_we = (state == BUSY) & req & last & op_wr_q & ~rst;

  // Combinational wait line: already high in the request cycle, low in DONE.
  assign bus.kp = req & (state != DONE) & ~rst;

  // Access sequencing, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            op_wr_q  <= bus.wr;   // rd and wr together count as a write
            cnt      <= '0;
            state    <= BUSY;
            bus.busy <= 1'b1;
          end
        end
        BUSY: begin
          if (!req) begin
            // Request withdrawn: abandon the access, rdata keeps its value.
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (last) begin
            if (!op_wr_q) begin
              bus.rdata <= mem[addr_q];
            end
            state    <= DONE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios followed by random
// reads/writes/aborts, checked against a transaction-level reference model.
module tb_mem_resp;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned WAIT = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_resp_if #(.AW(AW), .DW(DW)) bus ();

  mem_resp #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents written so far and the last read result.
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ref_rdata;
  int            addrs [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access. abort_at = 0 completes normally; k in 1..WAIT withdraws the
  // request in the k-th BUSY cycle. scr: 0 hold addr, 1 addr+1, 2 random
  // addr/wdata during the access.
  task automatic access(input bit do_rd, input bit do_wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int abort_at, input int scr,
                        input string tag);
    bit is_wr;
    is_wr = do_wr;
    next_cycle();
    bus.rd    = do_rd;
    bus.wr    = do_wr;
    bus.addr  = a;
    bus.wdata = d;
    for (int c = 0; c <= int'(WAIT) + 1; c++) begin
      if (abort_at != 0 && c == abort_at) begin
        bus.rd = 1'b0;
        bus.wr = 1'b0;
      end
      @(negedge clk);
      if (abort_at != 0 && c == abort_at) begin
        chk($sformatf("%s abort kp", tag), 32'(bus.kp), 32'(0));
        chk($sformatf("%s abort busy", tag), 32'(bus.busy), 32'(1));
        chk($sformatf("%s abort rdata", tag), 32'(bus.rdata), 32'(ref_rdata));
        break;
      end
      if (c == int'(WAIT) + 1) begin
        if (is_wr) begin
          if (!ref_mem.exists(int'(a))) addrs.push_back(int'(a));
          ref_mem[int'(a)] = d;
        end else begin
          ref_rdata = ref_mem[int'(a)];
        end
        chk($sformatf("%s done rdata", tag), 32'(bus.rdata), 32'(ref_rdata));
      end
      chk($sformatf("%s kp c%0d", tag, c), 32'(bus.kp), 32'(c <= int'(WAIT)));
      chk($sformatf("%s busy c%0d", tag, c), 32'(bus.busy),
          32'(c >= 1 && c <= int'(WAIT)));
      next_cycle();
      if (c < int'(WAIT) + 1) begin
        if (scr == 1) bus.addr = a + AW'(1);
        if (scr == 2) begin
          bus.addr  = AW'($urandom);
          bus.wdata = DW'($urandom);
        end
      end
    end
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    @(negedge clk);
    chk($sformatf("%s idle kp", tag), 32'(bus.kp), 32'(0));
    chk($sformatf("%s idle busy", tag), 32'(bus.busy), 32'(0));
    chk($sformatf("%s idle rdata", tag), 32'(bus.rdata), 32'(ref_rdata));
  endtask

  initial begin
    int ph;
    int kind;
    int ab;
    int scr;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_;

    // Reset with a pending read: kp must stay low.
    rst       = 1'b1;
    bus.rd    = 1'b1;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    ref_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset kp", 32'(bus.kp), 32'(0));
    chk("reset rdata", 32'(bus.rdata), 32'(0));
    chk("reset busy", 32'(bus.busy), 32'(0));
    next_cycle();
    rst    = 1'b0;
    bus.rd = 1'b0;
    @(negedge clk);
    chk("post-reset kp", 32'(bus.kp), 32'(0));
    chk("post-reset busy", 32'(bus.busy), 32'(0));

    // Write then read back.
    access(1'b0, 1'b1, 8'h12, 16'hBEEF, 0, 0, "wr12");
    access(1'b1, 1'b0, 8'h12, 16'h0000, 0, 0, "rd12");
    chk("rd12 value", 32'(bus.rdata), 32'h0000_BEEF);

    // Aborted write leaves the array untouched.
    access(1'b0, 1'b1, 8'h05, 16'h1234, 0, 0, "wr05");
    access(1'b0, 1'b1, 8'h05, 16'hAAAA, 2, 0, "abort05");
    access(1'b1, 1'b0, 8'h05, 16'h0000, 0, 0, "rd05");
    chk("rd05 value", 32'(bus.rdata), 32'h0000_1234);

    // Address change during BUSY is ignored.
    access(1'b0, 1'b1, 8'h20, 16'h0007, 0, 0, "wr20");
    access(1'b0, 1'b1, 8'h21, 16'h0099, 0, 0, "wr21");
    access(1'b1, 1'b0, 8'h20, 16'h0000, 0, 1, "rd20stab");
    chk("rd20 value", 32'(bus.rdata), 32'h0000_0007);

    // Back-to-back reads with rd held: completions every WAIT+2 cycles.
    next_cycle();
    bus.rd   = 1'b1;
    bus.addr = 8'h20;
    for (int c = 0; c < 2 * (int'(WAIT) + 2); c++) begin
      @(negedge clk);
      ph = c % (int'(WAIT) + 2);
      if (ph == int'(WAIT) + 1) begin
        ref_rdata = (c < int'(WAIT) + 2) ? 16'h0007 : 16'h0099;
        chk($sformatf("b2b rdata c%0d", c), 32'(bus.rdata), 32'(ref_rdata));
      end
      chk($sformatf("b2b kp c%0d", c), 32'(bus.kp), 32'(ph != int'(WAIT) + 1));
      next_cycle();
      if (c == int'(WAIT) + 1) bus.addr = 8'h21;
    end
    bus.rd = 1'b0;
    @(negedge clk);
    chk("b2b idle kp", 32'(bus.kp), 32'(0));
    chk("b2b idle busy", 32'(bus.busy), 32'(0));

    // Reset in the middle of a write.
    access(1'b0, 1'b1, 8'h30, 16'h5A5A, 0, 0, "wr30");
    next_cycle();
    bus.wr    = 1'b1;
    bus.addr  = 8'h30;
    bus.wdata = 16'hFFFF;
    next_cycle();
    @(negedge clk);
    chk("midrst busy before", 32'(bus.busy), 32'(1));
    chk("midrst kp before", 32'(bus.kp), 32'(1));
    #1;
    rst = 1'b1;
    #1;
    ref_rdata = '0;
    chk("midrst kp", 32'(bus.kp), 32'(0));
    chk("midrst rdata", 32'(bus.rdata), 32'(0));
    chk("midrst busy", 32'(bus.busy), 32'(0));
    next_cycle();
    bus.wr = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst release kp", 32'(bus.kp), 32'(0));
    access(1'b1, 1'b0, 8'h30, 16'h0000, 0, 0, "rd30");
    chk("rd30 value", 32'(bus.rdata), 32'h0000_5A5A);

    // Random mix of writes, reads, aborts and address/data scrambling.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WAIT)) : 0;
      scr  = int'($urandom_range(0, 2));
      rd_  = DW'($urandom);
      if (kind < 4 || addrs.size() == 0) begin
        ra = AW'($urandom);
        access(kind == 0, 1'b1, ra, rd_, ab, scr, $sformatf("rnd%0d wr", i));
      end else begin
        ra = AW'(addrs[$urandom_range(0, addrs.size() - 1)]);
        access(1'b1, 1'b0, ra, rd_, ab, scr, $sformatf("rnd%0d rd", i));
      end
    end

    // Read back every address written so far.
    foreach (addrs[k]) begin
      access(1'b1, 1'b0, AW'(addrs[k]), '0, 0, 0, $sformatf("final rd %0h", addrs[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound in case the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the CPU sequencer's multi-cycle bus.
- It accepts level-held read/write requests, holds the keep/wait line `kp` high while an access is in progress, and drops `kp` in the cycle the access completes.
- It contains a single-port DW x 2^AW storage array with a programmable fixed wait-state count.
- It sits between the CPU control unit (which stalls in its read states while `kp` = 1) and the storage array.

Parameters:
- AW, 8, address width; the array holds 2^AW words.
- DW, 16, data word width.
- WAIT, 2, wait-state cycles per access; legal range 1..15; counter width 4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd  input  1  read request; level, held by the CPU until it samples kp = 0.
- wr  input  1  write request; level, same hold rule as rd.
- addr  input  AW  word address; sampled at request acceptance.
- wdata  input  DW  write data; sampled at request acceptance.
- rdata  output  DW  registered read data; valid from the completion cycle until the next completed read.
- kp  output  1  keep/wait; 1 = access in progress, CPU must hold its state and request.
- busy  output  1  registered; 1 while the FSM is in BUSY.

Behaviour:
- Reset: clk and rst (asynchronous, active-high) as stated above.
  - State IDLE, counter 0, latched addr/wdata/op cleared, rdata = 0, busy = 0.
  - kp = 0 while rst = 1.
  - Array contents are not reset.
- States:
  - IDLE: if req = rd|wr, latch addr, wdata and op (write if wr = 1, else read), counter <= 0, go BUSY.
  - BUSY: if req drops, abort: go IDLE, no array write, rdata unchanged. Else if counter == WAIT-1, perform the access and go DONE. Else counter + 1.
  - DONE: unconditionally go IDLE after one cycle.
- Access at BUSY->DONE edge:
  - read: rdata <= mem[addr_q].
  - write: mem[addr_q] <= wdata_q; rdata unchanged.
- kp (combinational) = req & (state != DONE) & ~rst.
  - In IDLE with req it is already 1 in the request cycle.
  - In DONE it is 0, signalling completion to the CPU.
- Latency: request first asserted in cycle t.
  - kp = 1 in cycles t..t+WAIT.
  - kp = 0 and rdata valid in cycle t+WAIT+1.
  - The CPU advances on that edge.
- Back-to-back: a request present in the IDLE cycle after DONE is a new access with full latency; no pipelining.
- rd and wr both high: treated as a write.
- addr/wdata changes while in BUSY are ignored; latched values are used.
- rst asserted mid-access: immediate return to IDLE, no array write, rdata = 0.
- No request: kp = 0, state stays IDLE, outputs hold.

Test Plan:
- Reset check: rst = 1 with rd = 1 -> kp = 0, rdata = 0, busy = 0. Release rst with rd = 0 -> kp stays 0.
- Write then read, WAIT = 2:
  - wr = 1, addr = 0x12, wdata = 0xBEEF at t -> kp = 1 in t..t+2, kp = 0 at t+3; drop wr.
  - rd = 1, addr = 0x12 at t' -> kp = 0 and rdata = 0xBEEF at t'+3.
- Abort:
  - Write 0x1234 to 0x05; then wr = 1, addr = 0x05, wdata = 0xAAAA, drop wr after 1 BUSY cycle -> state IDLE.
  - Read 0x05 returns 0x1234.
- Address stability: rd = 1, addr = 0x20 (holding 0x0007), change addr to 0x21 during BUSY -> rdata = 0x0007.
- Back-to-back: rd held continuously at 0x20 then 0x21 -> two completions spaced WAIT+2 cycles, each with kp = 0 for exactly one cycle.
- Mid-access reset: assert rst during BUSY of a write to 0x30 -> kp = 0 immediately, rdata = 0. Later read of 0x30 returns the old value.
